stage_mem_wb: RTL and testbench
===============================

Name: stage_mem_wb

Overview:
- Memory stage plus MEM/WB pipeline register for the ARM 5-stage pipeline.
- Accepts EX results, performs data-memory load/store, and registers the result.
- Drives the write-back triple (wbWbEn, wbValue, wbDest) consumed by StageId's register-file write port.
- Also drives the next-cycle write-back information for the hazard/forwarding logic.

Parameters:
MEM_DEPTH, 64, number of 32-bit words in the data memory (power of 2)
MEM_BASE, 1024, byte address of data-memory word 0

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous reset, active-low
freeze  input  1  stall: hold memory and MEM/WB register
wbEnIn  input  1  EX/MEM write-back enable
memReadIn  input  1  EX/MEM load
memWriteEnIn  input  1  EX/MEM store
aluRes  input  32  EX/MEM ALU result / effective byte address
valRm  input  32  EX/MEM store data
destIn  input  4  EX/MEM destination register
wbWbEn  output  1  register-file write enable to ID
wbValue  output  32  register-file write data to ID
wbDest  output  4  register-file write index to ID
memOutValid  output  1  registered: last captured op was an in-range load

Behaviour:
- Reset (rst=0, async):
  - MEM/WB register cleared: wbWbEn=0, wbDest=0, wbValue=0, memOutValid=0.
  - All memory words cleared to 0.
  - Reset mid-operation drops any in-flight instruction; no store commits.
- Address mapping: wordAddr = (aluRes - MEM_BASE) >> 2. Low two bits are ignored (no alignment trap).
  - In range iff MEM_BASE <= aluRes < MEM_BASE + 4*MEM_DEPTH, as an unsigned 32-bit compare.
- Memory: asynchronous (combinational) read, synchronous write on the rising clk edge.
- On each rising edge with rst=1 and freeze=0:
  - Store:
    - If memWriteEnIn=1 and the address is in range: mem[wordAddr] <= valRm.
    - If out of range: write silently dropped.
  - MEM/WB register captures:
    - wbEnR <= wbEnIn & ~memWriteEnIn (a store never writes back).
    - destR <= destIn; aluResR <= aluRes.
    - memDataR <= the read value before this edge's write (read-before-write on same-address collision).
    - memReadR <= memReadIn & ~memWriteEnIn (store wins if both are asserted).
    - memOutValid <= memReadR-condition & in-range.
  - Out-of-range load: memDataR <= 0.
- freeze=1: no memory write and MEM/WB register holds, even if memWriteEnIn=1.
- Outputs:
  - wbWbEn = wbEnR; wbDest = destR.
  - wbValue = memReadR ? memDataR : aluResR (mux after the register).
- Latency: an instruction presented on the inputs in cycle N appears on the wb* outputs after the edge ending cycle N, i.e. usable by ID in cycle N+1.
  - Loaded data is visible to ID exactly one cycle after the load is presented.
  - A store followed by a load of the same address in the next cycle returns the stored value.
- Arithmetic: address subtraction is 32-bit unsigned. Addresses below MEM_BASE underflow and fail the range check.

Test Plan:
- Reset: rst=0 while inputs are active -> all outputs 0 immediately (async); after release with idle inputs, outputs stay 0.
- Store then load: cycle 1: memWriteEnIn=1, aluRes=1028, valRm=0xDEADBEEF, wbEnIn=1 -> wbWbEn=0 next cycle. Cycle 2: memReadIn=1, wbEnIn=1, aluRes=1028, destIn=5 -> next cycle wbWbEn=1, wbDest=5, wbValue=0xDEADBEEF, memOutValid=1.
- ALU pass-through: wbEnIn=1, memReadIn=0, aluRes=0x12345678, destIn=3 -> next cycle wbValue=0x12345678, wbDest=3, wbWbEn=1.
- Out of range: store to aluRes=1020 then load from 1020 -> wbValue=0, memOutValid=0. Load from word 0 (aluRes=1024) still returns 0.
- Freeze: hold freeze=1 for 2 cycles with a store to 1032 (value 7) asserted -> outputs unchanged; a later load of 1032 returns 0.
- Collision and wrap: same-edge store 0xA to 1024 plus read of 1024 -> captured memData is the old value; load 1024 at the next edge -> 0xA. Store to aluRes=1024+4*63 succeeds; aluRes=1024+4*64 is dropped.

Source files
------------

// File: rtl/stage_mem_wb.sv
// Memory stage and MEM/WB pipeline register: data-memory load/store on the EX result,
// then registers the write-back triple used by ID's register-file write port.
module stage_mem_wb #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned MEM_BASE  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        wbEnIn,
    input  logic        memReadIn,
    input  logic        memWriteEnIn,
    input  logic [31:0] aluRes,
    input  logic [31:0] valRm,
    input  logic [3:0]  destIn,
    output logic        wbWbEn,
    output logic [31:0] wbValue,
    output logic [3:0]  wbDest,
    output logic        memOutValid
);

    localparam int          AW   = $clog2(MEM_DEPTH);
    localparam logic [31:0] BASE = 32'(MEM_BASE);
    localparam logic [31:0] SPAN = 32'(4 * MEM_DEPTH);

    logic [31:0]   mem_q [MEM_DEPTH];

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_addr;
    logic [31:0]   rd_data;
    logic          is_load;

    logic          wb_en_d,   wb_en_q;
    logic [3:0]    dest_d,    dest_q;
    logic [31:0]   alu_res_d, alu_res_q;
    logic [31:0]   mem_data_d, mem_data_q;
    logic          mem_read_d, mem_read_q;
    logic          out_vld_d, out_vld_q;

    // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends.
    assign offset    = aluRes - BASE;
    assign in_range  = offset < SPAN;
    assign word_addr = offset[AW+1:2];
    assign rd_data   = in_range ? mem_q[word_addr] : '0;

    // A store takes priority over a simultaneous load request.
    assign is_load = memReadIn & ~memWriteEnIn;

    always_comb begin
        wb_en_d    = wbEnIn & ~memWriteEnIn;
        dest_d     = destIn;
        alu_res_d  = aluRes;
        mem_data_d = rd_data;
        mem_read_d = is_load;
        out_vld_d  = is_load & in_range;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (!freeze && memWriteEnIn && in_range) begin
            mem_q[word_addr] <= valRm;
        end
    end

    // MEM/WB boundary: rd_data is sampled before this edge's write lands (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            mem_read_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else if (!freeze) begin
            wb_en_q    <= wb_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            mem_data_q <= mem_data_d;
            mem_read_q <= mem_read_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign wbWbEn      = wb_en_q;
    assign wbDest      = dest_q;
    assign wbValue     = mem_read_q ? mem_data_q : alu_res_q;
    assign memOutValid = out_vld_q;

endmodule

// File: tb/tb_stage_mem_wb.sv
// Directed plus randomized bench for stage_mem_wb against a word-array reference model.
module tb_stage_mem_wb;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        wbEnIn;
    logic        memReadIn;
    logic        memWriteEnIn;
    logic [31:0] aluRes;
    logic [31:0] valRm;
    logic [3:0]  destIn;
    logic        wbWbEn;
    logic [31:0] wbValue;
    logic [3:0]  wbDest;
    logic        memOutValid;

    int total = 0;
    int bad   = 0;

    logic [31:0] mm [64];
    logic        e_en;
    logic [31:0] e_val;
    logic [3:0]  e_dest;
    logic        e_vld;

    stage_mem_wb #(.MEM_DEPTH(64), .MEM_BASE(1024)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wbEnIn(wbEnIn), .memReadIn(memReadIn), .memWriteEnIn(memWriteEnIn),
        .aluRes(aluRes), .valRm(valRm), .destIn(destIn),
        .wbWbEn(wbWbEn), .wbValue(wbValue), .wbDest(wbDest), .memOutValid(memOutValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".wbWbEn"}, {31'd0, wbWbEn}, {31'd0, e_en});
        chk({tag, ".wbDest"}, {28'd0, wbDest}, {28'd0, e_dest});
        chk({tag, ".wbValue"}, wbValue, e_val);
        chk({tag, ".memOutValid"}, {31'd0, memOutValid}, {31'd0, e_vld});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mm[i] = 32'd0;
        e_en = 1'b0; e_val = 32'd0; e_dest = 4'd0; e_vld = 1'b0;
    endtask

    // Byte window [1024, 1024 + 64*4) holds 64 words; anything else reads as 0 and ignores stores.
    task automatic model_edge();
        longint unsigned a;
        bit              inr;
        int              idx;
        logic [31:0]     old;
        bit              ld;
        if (freeze) return;
        a   = longint'(aluRes);
        inr = (a >= 1024) && (a < 1024 + 64 * 4);
        idx = inr ? int'((a - 1024) / 4) : 0;
        old = inr ? mm[idx] : 32'd0;
        ld  = memReadIn && !memWriteEnIn;
        if (memWriteEnIn && inr) mm[idx] = valRm;
        e_en   = wbEnIn && !memWriteEnIn;
        e_dest = destIn;
        e_vld  = ld && inr;
        e_val  = ld ? old : aluRes;
    endtask

    task automatic setin(input logic we, input logic rd, input logic en,
                         input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
        memWriteEnIn = we; memReadIn = rd; wbEnIn = en;
        aluRes = a; valRm = v; destIn = d;
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    initial begin
        freeze = 1'b0;
        rst    = 1'b1;
        setin(1'b1, 1'b0, 1'b1, 32'd1028, 32'h1111_2222, 4'd9);
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model("reset_active_inputs");
        chk("reset.wbValue_zero", wbValue, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        setin(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        cyc("idle_after_reset");

        // Store then load of the same word.
        setin(1'b1, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd2);
        cyc("store1028");
        chk("store.no_wb", {31'd0, wbWbEn}, 32'd0);
        setin(1'b0, 1'b1, 1'b1, 32'd1028, 32'd0, 4'd5);
        cyc("load1028");
        chk("load.value", wbValue, 32'hDEAD_BEEF);
        chk("load.dest", {28'd0, wbDest}, 32'd5);
        chk("load.valid", {31'd0, memOutValid}, 32'd1);

        setin(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'd0, 4'd3);
        cyc("alu_pass");
        chk("alu.value", wbValue, 32'h1234_5678);

        // Below the window: store dropped, load returns 0, word 0 untouched.
        setin(1'b1, 1'b0, 1'b0, 32'd1020, 32'hCAFE_F00D, 4'd0);
        cyc("store1020");
        setin(1'b0, 1'b1, 1'b1, 32'd1020, 32'd0, 4'd6);
        cyc("load1020");
        chk("oor.value", wbValue, 32'd0);
        chk("oor.valid", {31'd0, memOutValid}, 32'd0);
        setin(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd7);
        cyc("load1024_clean");
        chk("word0.value", wbValue, 32'd0);

        // Freeze: store must not commit and outputs hold.
        freeze = 1'b1;
        setin(1'b1, 1'b0, 1'b1, 32'd1032, 32'd7, 4'd8);
        cyc("freeze1");
        cyc("freeze2");
        chk("freeze.held_value", wbValue, 32'd0);
        freeze = 1'b0;
        setin(1'b0, 1'b1, 1'b1, 32'd1032, 32'd0, 4'd1);
        cyc("load1032_after_freeze");
        chk("freeze.no_store", wbValue, 32'd0);

        // Store with read also asserted: store wins; next load sees the new value.
        setin(1'b1, 1'b1, 1'b1, 32'd1024, 32'h0000_000A, 4'd4);
        cyc("collide_store");
        chk("collide.no_valid", {31'd0, memOutValid}, 32'd0);
        setin(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd4);
        cyc("collide_load");
        chk("collide.value", wbValue, 32'h0000_000A);

        // Top word is in range; one past the top is dropped and must not alias word 0.
        setin(1'b1, 1'b0, 1'b0, 32'd1276, 32'h5555_AAAA, 4'd0);
        cyc("store_top");
        setin(1'b1, 1'b0, 1'b0, 32'd1280, 32'h6666_0000, 4'd0);
        cyc("store_past_top");
        setin(1'b0, 1'b1, 1'b1, 32'd1276, 32'd0, 4'd10);
        cyc("load_top");
        chk("top.value", wbValue, 32'h5555_AAAA);
        setin(1'b0, 1'b1, 1'b1, 32'd1280, 32'd0, 4'd11);
        cyc("load_past_top");
        chk("past_top.valid", {31'd0, memOutValid}, 32'd0);
        setin(1'b0, 1'b1, 1'b1, 32'd1024, 32'd0, 4'd12);
        cyc("load_word0_after_wrap");
        chk("wrap.word0", wbValue, 32'h0000_000A);

        // Randomized traffic around the window.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = 32'd1000 + 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) a = $urandom;
            freeze = ($urandom_range(0, 7) == 0);
            setin(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
            cyc("random");
        end
        freeze = 1'b0;

        // Asynchronous reset mid-cycle with a store pending: nothing commits.
        setin(1'b1, 1'b0, 1'b1, 32'd1028, 32'h7777_7777, 4'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk_model("async_reset");
        @(negedge clk);
        rst = 1'b1;
        setin(1'b0, 1'b1, 1'b1, 32'd1028, 32'd0, 4'd5);
        cyc("load_after_reset");
        chk("reset.mem_cleared", wbValue, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
